// File: rtl/stage_pkg.sv
// Shared definitions for the pipeline stage blocks: display FSM encoding,
// enable polarity and the blank 7-segment pattern.
package stage_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    CAPT = 3'd2,
    SHOW = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic       EN_ACTIVE = 1'b0;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_BLANK  = 4'hF;

  // Active-low one-hot anode pattern for the selected digit
  function automatic logic [3:0] digitEnable(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern (bit6=g .. bit0=a).
module hex7seg_decoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_module.sv
// Display stage: fetches NUM_WORDS result words and scans each in hex on a
// 4-digit multiplexed 7-segment display, then flags completion.
module display_module
  import stage_pkg::*;
#(
  parameter int NUM_WORDS   = 4,
  parameter int ADDR_W      = 2,
  parameter int REFRESH_DIV = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_disp,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic              disp_done
);

  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(NUM_WORDS - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wordIdx_q, wordIdx_d;
  logic [ADDR_W-1:0]  rdAddr_q, rdAddr_d;
  logic [15:0]        shadow_q, shadow_d;
  logic [1:0]         digitSel_q, digitSel_d;
  logic [REF_W-1:0]   refCnt_q, refCnt_d;
  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               done_q, done_d;

  logic [3:0]         showNibble;
  logic [6:0]         showSeg;

  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    rdAddr_d   = rdAddr_q;
    shadow_d   = shadow_q;
    digitSel_d = digitSel_q;
    refCnt_d   = refCnt_q;
    holdCnt_d  = holdCnt_q;
    done_d     = done_q;

    // A released enable aborts from any active state, even on hold expiry
    if (state_q != IDLE && en_disp != EN_ACTIVE) begin
      state_d    = IDLE;
      wordIdx_d  = '0;
      rdAddr_d   = '0;
      digitSel_d = '0;
      refCnt_d   = '0;
      holdCnt_d  = '0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wordIdx_d = '0;
          done_d    = 1'b0;
          if (en_disp == EN_ACTIVE) begin
            state_d  = ADDR;
            rdAddr_d = '0;
          end
        end
        ADDR: state_d = CAPT;
        CAPT: begin
          shadow_d   = rd_data;
          digitSel_d = '0;
          refCnt_d   = '0;
          holdCnt_d  = '0;
          state_d    = SHOW;
        end
        SHOW, DONE: begin
          if (refCnt_q == REF_LAST) begin
            refCnt_d   = '0;
            digitSel_d = digitSel_q + 2'd1;
          end else begin
            refCnt_d = refCnt_q + 1'b1;
          end
          // DONE keeps scanning but never advances the word
          if (state_q == SHOW) begin
            if (holdCnt_q == HOLD_LAST) begin
              holdCnt_d = '0;
              if (wordIdx_q == WORD_LAST) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                wordIdx_d = wordIdx_q + 1'b1;
                rdAddr_d  = wordIdx_q + 1'b1;
                state_d   = ADDR;
              end
            end else begin
              holdCnt_d = holdCnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Segment registers load from next-state values so a digit lights on SHOW entry
  assign showNibble = shadow_d[{digitSel_d, 2'b00} +: 4];

  hex7seg_decoder u_decoder (
    .nibble_i (showNibble),
    .seg_o    (showSeg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_BLANK;
    if (state_d == SHOW || state_d == DONE) begin
      seg_d = showSeg;
      an_d  = digitEnable(digitSel_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wordIdx_q  <= '0;
      rdAddr_q   <= '0;
      shadow_q   <= 16'h0000;
      digitSel_q <= '0;
      refCnt_q   <= '0;
      holdCnt_q  <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= AN_BLANK;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordIdx_q  <= wordIdx_d;
      rdAddr_q   <= rdAddr_d;
      shadow_q   <= shadow_d;
      digitSel_q <= digitSel_d;
      refCnt_q   <= refCnt_d;
      holdCnt_q  <= holdCnt_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr   = rdAddr_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign disp_done = done_q;

endmodule
